vram_write_arbiter: RTL and testbench



---
 rtl/video_pkg.sv | 23 ++
 rtl/vram_wr_fifo.sv | 56 +++++
 rtl/vram_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_write_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types for the video RAM write path: fill FSM states and the CPU write FIFO entry.
package video_pkg;

  localparam int VRAM_BANK_WORDS = 8192;
  localparam int VRAM_ADDR_W     = 15;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  typedef struct packed {
    logic [13:0] addr;
    logic [15:0] data;
    logic [1:0]  wtbt;
  } fifo_entry_t;

  function automatic logic [13:0] fill_word_addr(input logic bank, input logic [12:0] cnt);
    return {bank, cnt};
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// CPU write-through FIFO. A full FIFO refuses a push even when a pop happens that same cycle.
module vram_wr_fifo import video_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fifo_entry_t            push_entry,
  input  logic                   pop,
  output fifo_entry_t            pop_entry,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fifo_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != DEPTH_C);
    pop_ok   = pop && (count_q != '0);
    mem_d    = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_entry;
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    // Full is a flop so the requester sees it in the same cycle the FIFO refuses pushes.
    full_d   = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  assign pop_entry = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = full_q;

endmodule

// File: rtl/vram_write_arbiter.sv
// Single write port of the dual-screen video RAM, shared by queued CPU writes and a bank fill engine.
module vram_write_arbiter import video_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int CPU_BURST  = 4,
  parameter int FILL_WORDS = VRAM_BANK_WORDS
) (
  input  logic                   clk_bus,
  input  logic                   bus_reset,
  input  logic [VRAM_ADDR_W-1:0] cpu_addr,
  input  logic [15:0]            cpu_data,
  input  logic [1:0]             cpu_wtbt,
  input  logic                   cpu_we,
  output logic                   cpu_busy,
  input  logic                   fill_start,
  input  logic                   fill_bank,
  input  logic [15:0]            fill_data,
  output logic                   fill_busy,
  output logic                   fill_done,
  output logic [VRAM_ADDR_W-1:0] cache_addr,
  output logic [15:0]            cache_data,
  output logic [1:0]             cache_wtbt,
  output logic                   cache_we
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CPU_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CPU_BURST);
  localparam logic [12:0]   LAST_WORD = 13'(FILL_WORDS - 1);

  fifo_entry_t   fifo_in, fifo_out;
  logic          fifo_push, fifo_pop, fifo_full;
  logic [CW-1:0] fifo_count;

  fill_state_e   state_q, state_d;
  logic          bank_q, bank_d;
  logic [15:0]   pat_q, pat_d;
  logic [12:0]   cnt_q, cnt_d;
  logic [BW-1:0] burst_q, burst_d;

  logic          grant_cpu, grant_fill;
  logic          s1_vld_q, s1_vld_d;
  fifo_entry_t   s1_ent_q, s1_ent_d;
  logic          cache_we_q, cache_we_d;
  fifo_entry_t   cache_ent_q, cache_ent_d;
  logic          fill_busy_q, fill_busy_d;
  logic          done_s1_q, done_s1_d;
  logic          fill_done_q, fill_done_d;

  // The byte lane select inside a word is carried by wtbt, so address bit 0 is dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = cpu_addr[0];

  assign fifo_in   = '{addr: cpu_addr[14:1], data: cpu_data, wtbt: cpu_wtbt};
  assign fifo_push = cpu_we && (cpu_wtbt != 2'b00);

  vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk_bus),
    .rst        (bus_reset),
    .push       (fifo_push),
    .push_entry (fifo_in),
    .pop        (fifo_pop),
    .pop_entry  (fifo_out),
    .count      (fifo_count),
    .full       (fifo_full)
  );

  always_comb begin
    grant_cpu  = (fifo_count != '0) && ((state_q != FILL_RUN) || (burst_q < BURST_MAX));
    grant_fill = !grant_cpu && (state_q == FILL_RUN);
    fifo_pop   = grant_cpu;

    state_d = state_q;
    bank_d  = bank_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    case (state_q)
      FILL_IDLE: if (fill_start) begin
        state_d = FILL_RUN;
        bank_d  = fill_bank;
        pat_d   = fill_data;
        cnt_d   = '0;
      end
      FILL_RUN: if (grant_fill) begin
        cnt_d = cnt_q + 13'd1;
        if (cnt_q == LAST_WORD) state_d = FILL_DONE;
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase

    // Burst only matters while a fill competes; CPU_BURST grants buy the fill one slot.
    burst_d = burst_q;
    if (state_q != FILL_RUN)       burst_d = '0;
    else if (grant_fill)           burst_d = '0;
    else if (burst_q != BURST_MAX) burst_d = burst_q + BW'(1);

    s1_vld_d = grant_cpu || grant_fill;
    s1_ent_d = s1_ent_q;
    if (grant_cpu)       s1_ent_d = fifo_out;
    else if (grant_fill) s1_ent_d = '{addr: fill_word_addr(bank_q, cnt_q), data: pat_q, wtbt: 2'b11};

    cache_we_d  = s1_vld_q;
    cache_ent_d = s1_vld_q ? s1_ent_q : cache_ent_q;

    // The done pulse rides two stages behind the FSM so it lands after the last write strobe.
    fill_busy_d = (state_d == FILL_RUN);
    done_s1_d   = (state_q == FILL_DONE);
    fill_done_d = done_s1_q;
  end

  always_ff @(posedge clk_bus) begin
    if (bus_reset) begin
      state_q     <= FILL_IDLE;
      bank_q      <= 1'b0;
      pat_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_ent_q    <= '0;
      cache_we_q  <= 1'b0;
      cache_ent_q <= '0;
      fill_busy_q <= 1'b0;
      done_s1_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      pat_q       <= pat_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      s1_vld_q    <= s1_vld_d;
      s1_ent_q    <= s1_ent_d;
      cache_we_q  <= cache_we_d;
      cache_ent_q <= cache_ent_d;
      fill_busy_q <= fill_busy_d;
      done_s1_q   <= done_s1_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign cpu_busy   = fifo_full;
  assign fill_busy  = fill_busy_q;
  assign fill_done  = fill_done_q;
  assign cache_we   = cache_we_q;
  assign cache_addr = {cache_ent_q.addr, 1'b0};
  assign cache_data = cache_ent_q.data;
  assign cache_wtbt = cache_ent_q.wtbt;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: vector table for single CPU writes, then fill sequences.
module tb_vram_write_arbiter;

  logic        clk_bus = 1'b0;
  logic        bus_reset = 1'b1;
  logic [14:0] cpu_addr = '0;
  logic [15:0] cpu_data = '0;
  logic [1:0]  cpu_wtbt = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_busy;
  logic        fill_start = 1'b0;
  logic        fill_bank = 1'b0;
  logic [15:0] fill_data = '0;
  logic        fill_busy, fill_done;
  logic [14:0] cache_addr;
  logic [15:0] cache_data;
  logic [1:0]  cache_wtbt;
  logic        cache_we;

  int total = 0;
  int bad   = 0;

  localparam int WORDS = 8192;
  localparam int BURST = 4;

  vram_write_arbiter dut (
    .clk_bus(clk_bus), .bus_reset(bus_reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wtbt(cpu_wtbt), .cpu_we(cpu_we),
    .cpu_busy(cpu_busy),
    .fill_start(fill_start), .fill_bank(fill_bank), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .cache_addr(cache_addr), .cache_data(cache_data), .cache_wtbt(cache_wtbt),
    .cache_we(cache_we)
  );

  always #5 clk_bus = ~clk_bus;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    logic [1:0]  wtbt;
    logic        exp_we;
    logic [14:0] exp_addr;
    logic [15:0] exp_data;
    logic [1:0]  exp_wtbt;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } cw_t;

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Runs one full fill and checks every write; optionally injects ignored requests mid-fill.
  task automatic fill_run(input logic bank, input logic [15:0] pat, input bit inject, input string tag);
    int nwr = 0, err = 0, first_c = -1, last_c = -1, done_c = -1, done_n = 0;
    fill_start = 1'b1; fill_bank = bank; fill_data = pat;
    tick();
    fill_start = 1'b0;
    chk({tag, "_busy_rise"}, fill_busy, 1);
    for (int c = 1; c <= 9000; c++) begin
      if (inject && c == 50) begin
        cpu_we = 1'b1; cpu_wtbt = 2'b00; cpu_addr = 15'h0040; cpu_data = 16'hDEAD;
        fill_start = 1'b1; fill_bank = ~bank; fill_data = ~pat;
      end
      tick();
      cpu_we = 1'b0; fill_start = 1'b0;
      if (cache_we) begin
        if ({cache_addr, cache_data, cache_wtbt} !== {bank, nwr[12:0], 1'b0, pat, 2'b11}) err++;
        if (first_c < 0) first_c = c;
        last_c = c;
        nwr++;
      end
      if (fill_done) begin done_n++; done_c = c; end
      if (done_n > 0 && c >= done_c + 5) break;
    end
    chk({tag, "_writes"}, nwr, WORDS);
    chk({tag, "_addr_data_err"}, err, 0);
    chk({tag, "_done_pulses"}, done_n, 1);
    chk({tag, "_done_after_last"}, done_c, last_c + 1);
    chk({tag, "_back_to_back"}, last_c - first_c, WORDS - 1);
    chk({tag, "_busy_fall"}, fill_busy, 0);
  endtask

  initial begin : main
    vec_t vecs[5];
    int   n;
    int   dn;
    vecs[0] = '{15'h0102, 16'hA55A, 2'b10, 1'b1, 15'h0102, 16'hA55A, 2'b10};
    vecs[1] = '{15'h0103, 16'h1234, 2'b01, 1'b1, 15'h0102, 16'h1234, 2'b01};
    vecs[2] = '{15'h7FFE, 16'hFFFF, 2'b11, 1'b1, 15'h7FFE, 16'hFFFF, 2'b11};
    vecs[3] = '{15'h4000, 16'h0001, 2'b00, 1'b0, 15'h7FFE, 16'hFFFF, 2'b11};
    vecs[4] = '{15'h2AAA, 16'hC3C3, 2'b11, 1'b1, 15'h2AAA, 16'hC3C3, 2'b11};

    repeat (3) tick();
    chk("rst_we", cache_we, 0);
    chk("rst_addr", cache_addr, 0);
    chk("rst_data", cache_data, 0);
    chk("rst_wtbt", cache_wtbt, 0);
    chk("rst_cpu_busy", cpu_busy, 0);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_fill_done", fill_done, 0);
    bus_reset = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      cpu_addr = vecs[i].addr; cpu_data = vecs[i].data; cpu_wtbt = vecs[i].wtbt; cpu_we = 1'b1;
      tick();
      cpu_we = 1'b0;
      chk($sformatf("v%0d_we_e0", i), cache_we, 0);
      tick();
      chk($sformatf("v%0d_we_e1", i), cache_we, 0);
      tick();
      chk($sformatf("v%0d_we_e2", i), cache_we, vecs[i].exp_we);
      chk($sformatf("v%0d_addr", i), cache_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_data", i), cache_data, vecs[i].exp_data);
      chk($sformatf("v%0d_wtbt", i), cache_wtbt, vecs[i].exp_wtbt);
      tick();
      chk($sformatf("v%0d_we_e3", i), cache_we, 0);
      chk($sformatf("v%0d_addr_hold", i), cache_addr, vecs[i].exp_addr);
    end

    fill_run(1'b1, 16'h0000, 1'b0, "fill1");

    // Reset in the middle of a fill: no done pulse, outputs drop, next fill restarts at word 0.
    fill_start = 1'b1; fill_bank = 1'b0; fill_data = 16'h1234;
    tick();
    fill_start = 1'b0;
    n = 0;
    for (int c = 0; c < 400 && n < 100; c++) begin
      tick();
      if (cache_we) n++;
    end
    chk("midrst_writes_before", n, 100);
    bus_reset = 1'b1;
    tick();
    bus_reset = 1'b0;
    chk("midrst_fill_busy", fill_busy, 0);
    chk("midrst_we", cache_we, 0);
    chk("midrst_done", fill_done, 0);
    n = 0; dn = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (cache_we) n++;
      if (fill_done) dn++;
    end
    chk("midrst_no_writes_after", n, 0);
    chk("midrst_no_done_after", dn, 0);

    fill_run(1'b0, 16'h5678, 1'b1, "refill_inject");

    begin : flood
      logic [15:0] seq;
      int acc, nc, nf, runc, perr, serr, done_c, drain;
      bit flooding, busy_seen;
      cw_t sb[$];
      cw_t e;
      seq = 16'h0100; acc = 0; nc = 0; nf = 0; runc = 0; perr = 0; serr = 0;
      done_c = -1; drain = 0; flooding = 1'b1; busy_seen = 1'b0;
      for (int c = 0; c < 46000 && drain < 20; c++) begin
        if (flooding) begin
          cpu_we = 1'b1; cpu_wtbt = 2'b01; cpu_addr = {1'b0, seq[12:0], 1'b0}; cpu_data = seq;
          if (!cpu_busy) begin
            e.addr = cpu_addr; e.data = seq;
            sb.push_back(e);
            acc++;
            seq++;
          end
        end else begin
          cpu_we = 1'b0;
        end
        fill_start = (c == 10);
        if (c == 10) begin fill_bank = 1'b1; fill_data = 16'hBEEF; end
        tick();
        if (cache_we) begin
          if (cache_wtbt == 2'b11) begin
            if ({cache_addr, cache_data} !== {1'b1, nf[12:0], 1'b0, 16'hBEEF}) serr++;
            if (nf > 0 && runc != BURST) perr++;
            nf++;
            runc = 0;
          end else begin
            nc++;
            runc++;
            if (sb.size() == 0) serr++;
            else begin
              e = sb.pop_front();
              if ({cache_addr, cache_data, cache_wtbt} !== {e.addr, e.data, 2'b01}) serr++;
            end
          end
        end
        if (cpu_busy) busy_seen = 1'b1;
        if (fill_done) begin done_c = c; flooding = 1'b0; end
        if (!flooding) drain++;
      end
      fill_start = 1'b0; cpu_we = 1'b0;
      chk("flood_done_seen", (done_c >= 0), 1);
      chk("flood_in_budget", (done_c >= 0) && (done_c - 10 <= WORDS * (BURST + 1) + 4), 1);
      chk("flood_fill_writes", nf, WORDS);
      chk("flood_grant_pattern_err", perr, 0);
      chk("flood_data_err", serr, 0);
      chk("flood_busy_seen", busy_seen, 1);
      chk("flood_written_eq_accepted", nc, acc);
      chk("flood_queue_drained", sb.size(), 0);
      chk("flood_busy_clear", cpu_busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
